// File: rtl/flash_fetch_responder_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// flash_fetch_responder_pkg : shared FSM encoding and NOP constant
// Rev 1.0
// ------------------------------------------------------------------
package flash_fetch_responder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/flash_fetch_responder_if.sv
`default_nettype none
// ------------------------------------------------------------------
// flash_fetch_responder_if : fetch port plus byte-wide flash handshake
// Rev 1.0
// ------------------------------------------------------------------
interface flash_fetch_responder_if #(
  parameter int FLASH_AW = 12
);
  logic [31:0]         pc_f;
  logic [31:0]         instr_f;
  logic                stall_f;
  logic                flash_req;
  logic [FLASH_AW-1:0] flash_addr;
  logic [7:0]          flash_rdata;
  logic                flash_ack;

  modport slave (
    input  pc_f, flash_rdata, flash_ack,
    output instr_f, stall_f, flash_req, flash_addr
  );

  modport master (
    output pc_f, flash_rdata, flash_ack,
    input  instr_f, stall_f, flash_req, flash_addr
  );
endinterface
`default_nettype wire

// File: rtl/flash_fetch_responder_word_buffer.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_word_buffer : single-entry tagged word buffer with hit compare
// Rev 1.0
// ------------------------------------------------------------------
module fetch_word_buffer
  import flash_fetch_responder_pkg::*;
#(
  parameter int TAG_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fill_en,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [31:0]      fill_data,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit,
  output logic [31:0]      rdata
);

  logic             valid_q, valid_d;
  logic [TAG_W-1:0] tag_q,   tag_d;
  logic [31:0]      data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d = 1'b1;
      tag_d   = fill_tag;
      data_d  = fill_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit   = valid_q && (tag_q == lookup_tag);
  assign rdata = data_q;

endmodule
`default_nettype wire

// File: rtl/flash_fetch_responder.sv
`default_nettype none
// ------------------------------------------------------------------
// flash_fetch_responder : serves fetch words from a byte-wide flash
// Rev 1.0
// ------------------------------------------------------------------
module flash_fetch_responder
  import flash_fetch_responder_pkg::*;
#(
  parameter int          FLASH_AW  = 12,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  flash_fetch_responder_if.slave  bus
);

  localparam int TAG_W = FLASH_AW - 2;

  logic [1:0]          state_q,      state_d;
  logic [TAG_W-1:0]    word_q,       word_d;
  logic [1:0]          byte_cnt_q,   byte_cnt_d;
  logic [31:0]         asm_q,        asm_d;
  logic                flash_req_q,  flash_req_d;
  logic [FLASH_AW-1:0] flash_addr_q, flash_addr_d;

  logic [TAG_W-1:0]    pc_word;
  logic                out_of_window;
  logic                hit;
  logic                miss;
  logic                redirect;
  logic                fill_en;
  logic [31:0]         buf_data;

  assign pc_word       = bus.pc_f[FLASH_AW-1:2];
  assign out_of_window = (bus.pc_f[31:FLASH_AW] != '0) || (bus.pc_f[1:0] != 2'b00);
  assign miss          = !out_of_window && !hit;
  // The in-flight byte always completes; only then is the new PC honoured.
  assign redirect      = out_of_window || (pc_word != word_q);

  fetch_word_buffer #(
    .TAG_W (TAG_W)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .fill_en    (fill_en),
    .fill_tag   (word_q),
    .fill_data  (asm_q),
    .lookup_tag (pc_word),
    .hit        (hit),
    .rdata      (buf_data)
  );

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    flash_req_d  = flash_req_q;
    flash_addr_d = flash_addr_q;
    fill_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (miss) begin
          word_d       = pc_word;
          byte_cnt_d   = 2'd0;
          flash_req_d  = 1'b1;
          flash_addr_d = {pc_word, 2'b00};
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.flash_ack && flash_req_q) begin
          asm_d[{byte_cnt_q, 3'b000} +: 8] = bus.flash_rdata;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (redirect) begin
            flash_req_d = 1'b0;
            state_d     = ST_IDLE;
          end else if (byte_cnt_q == 2'd3) begin
            flash_req_d = 1'b0;
            state_d     = ST_FILL;
          end else begin
            flash_addr_d = {word_q, byte_cnt_q + 2'd1};
          end
        end
      end
      ST_FILL: begin
        fill_en = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      word_q       <= '0;
      byte_cnt_q   <= 2'd0;
      asm_q        <= '0;
      flash_req_q  <= 1'b0;
      flash_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      flash_req_q  <= flash_req_d;
      flash_addr_q <= flash_addr_d;
    end
  end

  assign bus.flash_req  = flash_req_q;
  assign bus.flash_addr = flash_addr_q;
  assign bus.stall_f    = miss;
  assign bus.instr_f    = (hit && !out_of_window) ? buf_data : NOP_INSTR;

endmodule
`default_nettype wire

// File: tb/tb_flash_fetch_responder.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_flash_fetch_responder : directed + randomized bench with flash model
// Rev 1.0
// ------------------------------------------------------------------
module tb_flash_fetch_responder;
  import flash_fetch_responder_pkg::*;

  localparam int          AW  = 12;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;

  flash_fetch_responder_if #(.FLASH_AW(AW)) bus ();

  flash_fetch_responder #(
    .FLASH_AW  (AW),
    .NOP_INSTR (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:(1<<AW)-1];
  int         ack_delay = 0;
  int         checks = 0;
  int         passes = 0;
  int         addr_log[$];
  bit         mbuf_valid = 1'b0;
  int         mbuf_word = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_word(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  function automatic bit ref_oow(input logic [31:0] pc);
    return ((pc >> AW) != 0) || (pc[1:0] != 2'b00);
  endfunction

  // Flash model: acks each byte after ack_delay wait cycles, logs addresses.
  initial begin : flash_model
    int waited;
    int first_addr;
    waited = 0;
    first_addr = 0;
    bus.flash_ack   = 1'b0;
    bus.flash_rdata = 8'h00;
    forever begin
      @(negedge clk);
      bus.flash_ack = 1'b0;
      if (bus.flash_req !== 1'b1) begin
        waited = 0;
      end else begin
        if (waited == 0) begin
          first_addr = int'(bus.flash_addr);
          addr_log.push_back(first_addr);
        end else begin
          check("addr_stable", 32'(bus.flash_addr), 32'(first_addr));
        end
        if (waited >= ack_delay) begin
          bus.flash_ack   = 1'b1;
          bus.flash_rdata = mem[bus.flash_addr];
          waited = 0;
        end else begin
          waited++;
        end
      end
    end
  end

  task automatic fetch(input string tag, input logic [31:0] pc, input int delay);
    int          n;
    int          exp_n;
    logic [31:0] exp_i;
    bit          oow;
    bit          hitm;
    n     = 0;
    oow   = ref_oow(pc);
    hitm  = !oow && mbuf_valid && (mbuf_word == int'(pc >> 2));
    exp_n = (oow || hitm) ? 0 : 2 + 4 * (delay + 1);
    exp_i = oow ? NOP : ref_word(int'(pc));
    ack_delay = delay;
    addr_log.delete();
    @(negedge clk);
    bus.pc_f = pc;
    #2;
    while (bus.stall_f === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
      #2;
    end
    check({tag, "_stalls"}, 32'(n), 32'(exp_n));
    check({tag, "_instr"}, bus.instr_f, exp_i);
    if (!oow && !hitm) begin
      check({tag, "_nbytes"}, 32'(addr_log.size()), 32'd4);
      for (int i = 0; i < addr_log.size() && i < 4; i++)
        check({tag, "_addr"}, 32'(addr_log[i]), 32'(int'(pc) + i));
      mbuf_valid = 1'b1;
      mbuf_word  = int'(pc >> 2);
    end else begin
      repeat (2) @(negedge clk);
      #2;
      check({tag, "_noreq"}, 32'(bus.flash_req), 32'd0);
      check({tag, "_nostall"}, 32'(bus.stall_f), 32'd0);
      check({tag, "_nolog"}, 32'(addr_log.size()), 32'd0);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    int exp_addrs[$];
    for (int i = 0; i < (1 << AW); i++)
      mem[i] = (i < 16) ? 8'(i + 1) : 8'($urandom);

    rst      = 1'b1;
    bus.pc_f = 32'h2;
    repeat (3) @(negedge clk);
    #2;
    check("rst_req",   32'(bus.flash_req),  32'd0);
    check("rst_addr",  32'(bus.flash_addr), 32'd0);
    check("rst_stall", 32'(bus.stall_f),    32'd0);
    check("rst_instr", bus.instr_f,         NOP);
    @(negedge clk);
    rst = 1'b0;

    fetch("first", 32'h0, 0);
    check("first_const", bus.instr_f, 32'h04030201);
    fetch("hit0", 32'h0, 0);
    fetch("slow4", 32'h4, 2);
    fetch("oow_hi", 32'h0000_1000, 0);
    fetch("oow_mis", 32'h2, 0);

    // Redirect from word 8 to word 12 while byte 2 of word 8 is in flight.
    ack_delay = 1;
    addr_log.delete();
    @(negedge clk);
    bus.pc_f = 32'd8;
    #2;
    n = 0;
    while (addr_log.size() < 3 && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("redir_reach", 32'(n < 100), 32'd1);
    bus.pc_f = 32'd12;
    n = 0;
    while (bus.stall_f === 1'b1 && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("redir_instr", bus.instr_f, ref_word(12));
    exp_addrs = '{8, 9, 10, 12, 13, 14, 15};
    check("redir_nbytes", 32'(addr_log.size()), 32'd7);
    for (int i = 0; i < addr_log.size() && i < 7; i++)
      check("redir_addr", 32'(addr_log[i]), 32'(exp_addrs[i]));
    mbuf_valid = 1'b1;
    mbuf_word  = 3;
    fetch("refetch8", 32'd8, 0);

    // Reset in the middle of a word fill.
    ack_delay = 0;
    addr_log.delete();
    @(negedge clk);
    bus.pc_f = 32'd20;
    #2;
    n = 0;
    while (addr_log.size() < 2 && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("rstreq_reach", 32'(n < 100), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    #2;
    check("rstreq_req",  32'(bus.flash_req),  32'd0);
    check("rstreq_addr", 32'(bus.flash_addr), 32'd0);
    bus.pc_f   = 32'h2;
    mbuf_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    fetch("refill0", 32'h0, 0);
    check("refill0_const", bus.instr_f, 32'h04030201);

    for (int k = 0; k < 8; k++) begin
      logic [31:0] pc;
      int          d;
      pc = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      if (k == 5) pc = pc | 32'h0001_0000;
      d = $urandom_range(0, 3);
      fetch("rnd", pc, d);
      fetch("rnd_hit", pc, d);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
